// File: rtl/systolic_feeder.sv
// Front end of the N x N systolic array: latches weights, skews input vectors into the
// diagonal wavefront, drains the skew with zeros and signals completion.
module systolic_feeder #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         weight_valid,
    input  logic [N*N*DATA_WIDTH-1:0]    weight_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [N*DATA_WIDTH-1:0]      in_data,
    output logic                         in_ready,
    output logic                         load_weight,
    output logic [N*N*DATA_WIDTH-1:0]    weight_out,
    output logic                         start,
    output logic [N*DATA_WIDTH-1:0]      row_in,
    output logic                         done
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((N > 1) ? N - 2 : 0);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic          adv;
    logic          adv_last;
    logic          fin;
    logic          weight_take;

    always_comb begin
        in_ready = !rst && ((state == IDLE && !weight_valid) || state == STREAM);
    end

    assign accept      = in_valid && in_ready;
    assign weight_take = (state == IDLE) && weight_valid;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        adv       = 1'b0;
        adv_last  = 1'b0;
        case (state)
            IDLE, STREAM: begin
                if (state == IDLE && weight_valid) begin
                    state_nxt = LOAD;
                end else if (accept) begin
                    adv = 1'b1;
                    if (in_last) begin
                        if (N > 1) begin
                            state_nxt = DRAIN;
                            cnt_nxt   = '0;
                        end else begin
                            adv_last  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        state_nxt = STREAM;
                    end
                end
            end
            LOAD: state_nxt = IDLE;
            DRAIN: begin
                adv = 1'b1;
                if (cnt == CNT_LAST) begin
                    adv_last  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // fin marks the cycle the final advance is presented; done follows it by one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start       <= 1'b0;
            fin         <= 1'b0;
            done        <= 1'b0;
            load_weight <= 1'b0;
            weight_out  <= '0;
        end else begin
            start       <= adv;
            fin         <= adv_last;
            done        <= fin;
            load_weight <= weight_take;
            if (weight_take) begin
                weight_out <= weight_data;
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        logic [DATA_WIDTH-1:0] chain [r+1];

        // an advance coinciding with the clear shifts in behind a zeroed chain anyway
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned j = 0; j <= unsigned'(r); j++) begin
                    chain[j] <= '0;
                end
            end else if (adv) begin
                chain[0] <= (state == DRAIN) ? '0 : in_data[r*DATA_WIDTH +: DATA_WIDTH];
                for (int unsigned j = 1; j <= unsigned'(r); j++) begin
                    chain[j] <= chain[j-1];
                end
            end else if (fin) begin
                for (int unsigned j = 0; j <= unsigned'(r); j++) begin
                    chain[j] <= '0;
                end
            end
        end

        assign row_in[r*DATA_WIDTH +: DATA_WIDTH] = chain[r];
    end

endmodule
